// File: rtl/bit_scan_serializer.sv
// Tick-stepped serializer: captures a WIDTH-bit word and presents one bit per tick
// on dout, LSB- or MSB-first, with one-shot or auto-reload framing and abort.
module bit_scan_serializer #(
  parameter int unsigned WIDTH      = 16,
  parameter logic        IDLE_LEVEL = 1'b0,
  localparam int unsigned IDXW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             continuous,
  input  logic             stop,
  output logic             dout,
  output logic [IDXW-1:0]  bit_idx,
  output logic             busy,
  output logic             ready,
  output logic             done
);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_e;

  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             order_q, order_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             done_q, done_d;

  logic [IDXW-1:0]  first_acc, first_cur, last_cur;

  // first_acc uses the live order input (accept); first_cur/last_cur use the latched order
  assign first_acc = msb_first ? IDX_MAX : '0;
  assign first_cur = order_q ? IDX_MAX : '0;
  assign last_cur  = order_q ? '0 : IDX_MAX;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    order_d  = order_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_SCAN;
          shadow_d = din;
          order_d  = msb_first;
          idx_d    = first_acc;
        end
      end
      S_SCAN: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (tick) begin
          if (idx_q == last_cur) begin
            done_d = 1'b1;
            if (continuous) begin
              shadow_d = din;
              idx_d    = first_cur;
            end else begin
              state_d = S_IDLE;
              idx_d   = '0;
            end
          end else if (order_q) begin
            idx_d = idx_q - IDXW'(1);
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      order_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      order_q  <= order_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (state_q == S_SCAN);
  assign ready   = ~busy;
  assign done    = done_q;
  assign bit_idx = idx_q;
  assign dout    = busy ? shadow_q[idx_q] : IDLE_LEVEL;

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Scoreboard bench: three widths (16, 5, 8) share stimulus; a frame-level model
// queues expected outputs per cycle and a negedge monitor compares them.
module tb_bit_scan_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, start, stop, msb_first, continuous;
  logic [15:0] din;

  logic        dout0, busy0, ready0, done0;
  logic [3:0]  idx0;
  logic        dout1, busy1, ready1, done1;
  logic [2:0]  idx1;
  logic        dout2, busy2, ready2, done2;
  logic [2:0]  idx2;

  always #5 clk = ~clk;

  bit_scan_serializer #(.WIDTH(16), .IDLE_LEVEL(1'b0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .din(din),
    .msb_first(msb_first), .continuous(continuous), .stop(stop),
    .dout(dout0), .bit_idx(idx0), .busy(busy0), .ready(ready0), .done(done0)
  );

  bit_scan_serializer #(.WIDTH(5), .IDLE_LEVEL(1'b0)) u_w5 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .din(din[4:0]),
    .msb_first(msb_first), .continuous(continuous), .stop(stop),
    .dout(dout1), .bit_idx(idx1), .busy(busy1), .ready(ready1), .done(done1)
  );

  bit_scan_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .din(din[7:0]),
    .msb_first(msb_first), .continuous(continuous), .stop(stop),
    .dout(dout2), .bit_idx(idx2), .busy(busy2), .ready(ready2), .done(done2)
  );

  typedef struct packed {
    logic [2:0]      busy;
    logic [2:0]      dout;
    logic [2:0]      done;
    logic [2:0][3:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Frame-level reference: k counts bits consumed in the current frame;
  // the presented index is derived from k and the latched order.
  int unsigned W [3] = '{16, 5, 8};
  logic [15:0] m_bits [3];
  logic        m_busy [3];
  logic        m_order[3];
  logic        m_done [3];
  int unsigned m_k    [3];

  initial begin
    for (int n = 0; n < 3; n++) begin
      m_bits[n] = '0; m_busy[n] = 1'b0; m_order[n] = 1'b0; m_done[n] = 1'b0; m_k[n] = 0;
    end
  end

  always @(posedge clk) begin
    exp_t        e;
    int unsigned pos;
    logic [15:0] msk;
    e = '0;
    for (int n = 0; n < 3; n++) begin
      msk = 16'((32'd1 << W[n]) - 32'd1);
      if (!rst_n) begin
        m_busy[n] = 1'b0; m_bits[n] = '0; m_order[n] = 1'b0; m_k[n] = 0; m_done[n] = 1'b0;
      end else begin
        m_done[n] = 1'b0;
        if (!m_busy[n]) begin
          if (start && !stop) begin
            m_busy[n] = 1'b1; m_bits[n] = din & msk; m_order[n] = msb_first; m_k[n] = 0;
          end
        end else if (stop) begin
          m_busy[n] = 1'b0;
        end else if (tick) begin
          if (m_k[n] == W[n] - 1) begin
            m_done[n] = 1'b1;
            m_k[n]    = 0;
            if (continuous) m_bits[n] = din & msk;
            else            m_busy[n] = 1'b0;
          end else begin
            m_k[n] = m_k[n] + 1;
          end
        end
      end
      pos = m_order[n] ? (W[n] - 1 - m_k[n]) : m_k[n];
      e.busy[n] = m_busy[n];
      e.done[n] = m_done[n];
      e.idx[n]  = m_busy[n] ? 4'(pos) : 4'd0;
      e.dout[n] = m_busy[n] ? m_bits[n][pos] : 1'b0;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t       e;
    logic       a_busy, a_rdy, a_dout, a_done;
    logic [3:0] a_idx;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;  // asynchronous reset forces outputs before the model sees an edge
      for (int n = 0; n < 3; n++) begin
        case (n)
          0:       begin a_busy = busy0; a_rdy = ready0; a_dout = dout0; a_done = done0; a_idx = idx0; end
          1:       begin a_busy = busy1; a_rdy = ready1; a_dout = dout1; a_done = done1; a_idx = {1'b0, idx1}; end
          default: begin a_busy = busy2; a_rdy = ready2; a_dout = dout2; a_done = done2; a_idx = {1'b0, idx2}; end
        endcase
        n_checks++;
        if (a_busy === e.busy[n] && a_rdy === ~e.busy[n] && a_dout === e.dout[n] &&
            a_done === e.done[n] && a_idx === e.idx[n]) begin
          n_pass++;
        end else begin
          $display("FAIL w%0d_outputs t=%0t got busy=%b ready=%b dout=%b idx=%0d done=%b exp busy=%b ready=%b dout=%b idx=%0d done=%b",
                   W[n], $time, a_busy, a_rdy, a_dout, a_idx, a_done,
                   e.busy[n], ~e.busy[n], e.dout[n], e.idx[n], e.done[n]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    n_checks++;
    if ({busy0, busy1, busy2} === 3'b000 && {ready0, ready1, ready2} === 3'b111 &&
        {dout0, dout1, dout2} === 3'b000 && {done0, done1, done2} === 3'b000 &&
        idx0 === 4'd0 && idx1 === 3'd0 && idx2 === 3'd0) begin
      n_pass++;
    end else begin
      $display("FAIL reset_state %s t=%0t busy=%b%b%b ready=%b%b%b dout=%b%b%b done=%b%b%b idx=%0d/%0d/%0d",
               tag, $time, busy0, busy1, busy2, ready0, ready1, ready2,
               dout0, dout1, dout2, done0, done1, done2, idx0, idx1, idx2);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int cnt;
    cnt = 0;
    while ((busy0 || busy1 || busy2) && cnt < max_cycles) begin
      step(1);
      cnt++;
    end
    n_checks++;
    if (!(busy0 || busy1 || busy2)) begin
      n_pass++;
    end else begin
      $display("FAIL wait_idle %s t=%0t timed out after %0d cycles busy=%b%b%b",
               tag, $time, max_cycles, busy0, busy1, busy2);
    end
  endtask

  task automatic do_start(input logic [15:0] d, input logic msb, input logic cont);
    din = d; msb_first = msb; continuous = cont; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      if (gap > 1) step(gap - 1);
    end
  endtask

  task automatic abort();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
    msb_first = 1'b0; continuous = 1'b0; din = '0;
    step(3);
    check_reset("power_on");
    rst_n = 1'b1;
    step(2);

    // reset mid-frame
    do_start(16'hA5C3, 1'b0, 1'b0);
    ticks(3, 5);
    rst_n = 1'b0;
    #1;
    check_reset("mid_frame");
    step(2);
    rst_n = 1'b1;
    step(2);

    // LSB-first one-shot
    do_start(16'hA5C3, 1'b0, 1'b0);
    ticks(16, 5);
    wait_idle("lsb_oneshot", 10);
    step(5);

    // MSB-first, 5'b10110 on the 5-bit instance
    abort();
    do_start(16'h0016, 1'b1, 1'b0);
    ticks(5, 3);
    step(3);
    abort();
    wait_idle("msb_w5", 10);

    // continuous reload with din changing mid-frame
    do_start(16'h00F0, 1'b0, 1'b1);
    ticks(3, 2);
    din = 16'h000F;
    ticks(5, 2);
    ticks(3, 2);
    continuous = 1'b0;
    ticks(5, 2);
    step(3);
    abort();
    wait_idle("continuous", 10);

    // start coincident with tick, start while busy, stop with last tick
    din = 16'h5A3C; msb_first = 1'b0; continuous = 1'b0;
    tick = 1'b1; start = 1'b1;
    step(1);
    tick = 1'b0; start = 1'b0;
    step(3);
    ticks(2, 2);
    din = 16'hFFFF; start = 1'b1;
    step(1);
    start = 1'b0;
    ticks(5, 2);
    tick = 1'b1; stop = 1'b1;
    step(1);
    tick = 1'b0; stop = 1'b0;
    step(3);

    // start during the done cycle of a one-shot
    abort();
    do_start(16'h0013, 1'b0, 1'b0);
    ticks(4, 2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    din = 16'h000A; msb_first = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
    ticks(6, 2);
    step(3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick  = ($urandom_range(0, 2) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) continuous = ~continuous;
      msb_first = 1'($urandom_range(0, 1));
      din   = 16'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    rst_n = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
    step(4);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
